// File: rtl/adc_spi_master.sv
// SPI mode-0 master for an MCP3202-style 12-bit ADC; SCLK is derived from Clk.
// Optional `ADC_SPI_AVG_EN: publish the truncated mean of every four conversions.
module adc_spi_master #(
    parameter int CLK_DIV = 25,
    parameter int CHANNEL = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        MISO,
    output logic        SCLK,
    output logic        CS,
    output logic        MOSI,
    output logic [11:0] Sample,
    output logic        SampleValid,
    output logic        Busy
);
    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    LAST_BIT  = 5'd16;
    localparam logic [4:0]    DATA_BIT0 = 5'd5;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [4:0]      bit_reg;
    logic [1:0]      miso_sync_reg;
    logic [10:0]     shift_reg;
    logic            sclk_reg;
    logic            cs_reg;
    logic            mosi_reg;
    logic [11:0]     sample_reg;
    logic            valid_reg;
    logic            busy_reg;
    logic [31:0]     cmd_word;
    logic [11:0]     result_next;

    // Frame bits 0..3: start, single-ended, channel select, MSB-first; zeros after.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cmd
            if (gi == 2) begin : g_odd
                assign cmd_word[gi] = (CHANNEL != 0);
            end else begin : g_fixed
                assign cmd_word[gi] = (gi < 4);
            end
        end
    endgenerate

    // Bits 5..15 are already shifted in; the final bit arrives on the commit cycle.
    assign result_next = {shift_reg, miso_sync_reg[1]};

`ifdef ADC_SPI_AVG_EN
    logic [13:0] acc_reg;
    logic [1:0]  avg_cnt_reg;
    logic [13:0] acc_sum;

    assign acc_sum = acc_reg + {2'b00, result_next};
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            miso_sync_reg <= '0;
            shift_reg     <= '0;
            sclk_reg      <= 1'b0;
            cs_reg        <= 1'b1;
            mosi_reg      <= 1'b0;
            sample_reg    <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef ADC_SPI_AVG_EN
            acc_reg       <= '0;
            avg_cnt_reg   <= '0;
`endif
        end else begin
            miso_sync_reg <= {miso_sync_reg[0], MISO};
            valid_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cs_reg   <= 1'b1;
                    sclk_reg <= 1'b0;
                    mosi_reg <= 1'b0;
                    cnt_reg  <= '0;
                    bit_reg  <= '0;
                    if (En) begin
                        state_reg <= SETUP;
                        cs_reg    <= 1'b0;
                        mosi_reg  <= cmd_word[0];
                        busy_reg  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_reg == HALF_LAST) begin
                        state_reg <= SHIFT;
                        sclk_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != HALF_LAST) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                            bit_reg  <= bit_reg + 5'd1;
                        end else if (bit_reg == LAST_BIT) begin
                            state_reg <= HOLD;
                            sclk_reg  <= 1'b0;
                            cs_reg    <= 1'b1;
                            mosi_reg  <= 1'b0;
`ifdef ADC_SPI_AVG_EN
                            avg_cnt_reg <= avg_cnt_reg + 2'd1;
                            if (avg_cnt_reg == 2'd3) begin
                                sample_reg <= acc_sum[13:2];
                                valid_reg  <= 1'b1;
                                acc_reg    <= '0;
                            end else begin
                                acc_reg <= acc_sum;
                            end
`else
                            sample_reg <= result_next;
                            valid_reg  <= 1'b1;
`endif
                        end else begin
                            // Falling edge: sample MISO late in the high half, present next command bit.
                            sclk_reg <= 1'b0;
                            mosi_reg <= cmd_word[bit_reg + 5'd1];
                            if (bit_reg >= DATA_BIT0) begin
                                shift_reg <= result_next[10:0];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign SCLK        = sclk_reg;
    assign CS          = cs_reg;
    assign MOSI        = mosi_reg;
    assign Sample      = sample_reg;
    assign SampleValid = valid_reg;
    assign Busy        = busy_reg;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master (CLK_DIV=4): ADC model on MISO, timing derived from H.
module tb_adc_spi_master;
    localparam int H     = 4;
    localparam int FRAME = 36 * H + 1;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        En;
    logic        En0;
    logic        MISO;
    logic        MISO0;
    logic        SCLK, CS, MOSI, SampleValid, Busy;
    logic [11:0] Sample;
    logic        SCLK0, CS0, MOSI0, SampleValid0, Busy0;
    logic [11:0] Sample0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    adc_spi_master #(.CLK_DIV(H), .CHANNEL(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .En(En), .MISO(MISO),
        .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .Sample(Sample), .SampleValid(SampleValid), .Busy(Busy)
    );

    adc_spi_master #(.CLK_DIV(H), .CHANNEL(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .En(En0), .MISO(MISO0),
        .SCLK(SCLK0), .CS(CS0), .MOSI(MOSI0),
        .Sample(Sample0), .SampleValid(SampleValid0), .Busy(Busy0)
    );

    assign MISO0 = 1'b0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // ADC model: one word per frame, null bit then B11..B0 after successive SCLK falls.
    logic [11:0] adc_q[$];
    logic [11:0] adc_word = 12'h000;
    int          adc_fe = 0;
    logic        mon_cs_prev = 1'b1, mon_sclk_prev = 1'b0;
    logic        mon_cs0_prev = 1'b1, mon_sclk0_prev = 1'b0;
    int          cs_falls = 0;
    logic [16:0] cap1 = '0, cap0 = '0;
    int          cap_n1 = 0, cap_n0 = 0;

    always @(posedge Clk) begin
        mon_cs_prev    <= CS;
        mon_sclk_prev  <= SCLK;
        mon_cs0_prev   <= CS0;
        mon_sclk0_prev <= SCLK0;
        if (CS) begin
            adc_fe <= 0;
            MISO   <= 1'b0;
        end else if (mon_cs_prev) begin
            adc_fe <= 0;
            MISO   <= 1'b0;
            if (adc_q.size() > 0) adc_word <= adc_q.pop_front();
            else adc_word <= 12'h000;
        end else if (mon_sclk_prev && !SCLK) begin
            adc_fe <= adc_fe + 1;
            if (adc_fe + 1 >= 5 && adc_fe + 1 <= 16) MISO <= adc_word[16 - (adc_fe + 1)];
            else MISO <= 1'b0;
        end
        if (mon_cs_prev && !CS) begin
            cs_falls <= cs_falls + 1;
            cap1     <= '0;
            cap_n1   <= 0;
        end else if (!mon_sclk_prev && SCLK) begin
            cap1   <= cap1 | (17'(MOSI) << cap_n1);
            cap_n1 <= cap_n1 + 1;
        end
        if (mon_cs0_prev && !CS0) begin
            cap0   <= '0;
            cap_n0 <= 0;
        end else if (!mon_sclk0_prev && SCLK0) begin
            cap0   <= cap0 | (17'(MOSI0) << cap_n0);
            cap_n0 <= cap_n0 + 1;
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge Clk);
        while (Busy && k < 4 * FRAME) begin
            @(negedge Clk);
            k++;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_vec++; if (CS !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", CS); end
        n_vec++; if (SCLK !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        n_vec++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        n_vec++; if (Sample !== 12'h000) begin n_err++; $display("FAIL reset_sample: got %h want 000", Sample); end
        n_vec++; if (SampleValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", SampleValid); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_vec++; if ({CS0, SCLK0, SampleValid0, Busy0} !== 4'b1000) begin
            n_err++; $display("FAIL reset_dut0: got cs/sclk/valid/busy=%b want 1000", {CS0, SCLK0, SampleValid0, Busy0});
        end
        n_vec++; if (Sample0 !== 12'h000) begin n_err++; $display("FAIL reset_sample0: got %h want 000", Sample0); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat ($urandom_range(2, 6)) @(posedge Clk);
        $display("reset: outputs checked at cycle %0d", cyc);
    endtask

    task automatic test_single();
        logic [11:0] val = 12'hA5C;
        logic [11:0] v_samp = 12'h000;
        int t, cs_first = -1, cs_last = -1, v_cnt = 0, v_cyc = -1, busy_fall = -1;
        adc_q.delete();
        adc_q.push_back(val);
        @(posedge Clk); #1;
        En = 1'b1;
        t  = cyc;
        @(posedge Clk); #1;
        En = 1'b0;
        for (int i = 0; i < 40 * H; i++) begin
            @(negedge Clk);
            if (!CS) begin
                if (cs_first < 0) cs_first = cyc;
                cs_last = cyc;
            end
            if (SampleValid) begin v_cnt++; v_cyc = cyc; v_samp = Sample; end
            if (cs_first >= 0 && busy_fall < 0 && !Busy) busy_fall = cyc;
        end
        n_vec++; if (cs_first !== t + 1) begin n_err++; $display("FAIL single_cs_fall: got t+%0d want t+%0d", cs_first - t, 1); end
        n_vec++; if (cs_last !== t + 34 * H) begin n_err++; $display("FAIL single_cs_last_low: got t+%0d want t+%0d", cs_last - t, 34 * H); end
        n_vec++; if (v_cnt !== 1) begin n_err++; $display("FAIL single_valid_count: got %0d want 1", v_cnt); end
        n_vec++; if (v_cyc !== t + 34 * H + 1) begin n_err++; $display("FAIL single_valid_time: got t+%0d want t+%0d", v_cyc - t, 34 * H + 1); end
        n_vec++; if (v_samp !== val) begin n_err++; $display("FAIL single_sample: got %h want %h", v_samp, val); end
        n_vec++; if (busy_fall !== t + 36 * H + 1) begin n_err++; $display("FAIL single_busy_fall: got t+%0d want t+%0d", busy_fall - t, 36 * H + 1); end
        $display("single: sample=%h expected=%h valid at t+%0d", v_samp, val, v_cyc - t);
    endtask

    task automatic test_command_bits();
        logic [16:0] exp1 = 17'h0000F;  // start, sgl, odd=1, msbf
        logic [16:0] exp0 = 17'h0000B;  // start, sgl, odd=0, msbf
        adc_q.delete();
        adc_q.push_back(12'($urandom));
        @(posedge Clk); #1;
        En = 1'b1; En0 = 1'b1;
        @(posedge Clk); #1;
        En = 1'b0; En0 = 1'b0;
        repeat (FRAME + 4) @(negedge Clk);
        n_vec++; if (cap_n1 !== 17) begin n_err++; $display("FAIL cmd_edges_ch1: got %0d want 17", cap_n1); end
        n_vec++; if (cap1 !== exp1) begin n_err++; $display("FAIL cmd_bits_ch1: got %b want %b", cap1, exp1); end
        n_vec++; if (cap_n0 !== 17) begin n_err++; $display("FAIL cmd_edges_ch0: got %0d want 17", cap_n0); end
        n_vec++; if (cap0 !== exp0) begin n_err++; $display("FAIL cmd_bits_ch0: got %b want %b", cap0, exp0); end
        $display("command: ch1 mosi=%b ch0 mosi=%b", cap1, cap0);
    endtask

    task automatic test_back_to_back();
        logic [11:0] vals[5];
        logic [11:0] vs[5];
        int          vcyc[5];
        int          n = 0, falls0, bad = 0;
        logic        ps, pc;
        vals[0] = 12'h001; vals[1] = 12'hFFF; vals[2] = 12'h800;
        vals[3] = 12'($urandom); vals[4] = 12'($urandom);
        for (int i = 0; i < 5; i++) begin vs[i] = 12'h000; vcyc[i] = 0; end
        adc_q.delete();
        for (int i = 0; i < 5; i++) adc_q.push_back(vals[i]);
        falls0 = cs_falls;
        @(posedge Clk); #1;
        En = 1'b1;
        ps = SCLK; pc = CS;
        for (int i = 0; i < 6 * FRAME && n < 5; i++) begin
            @(negedge Clk);
            if (SCLK !== ps && CS && pc) bad++;
            ps = SCLK; pc = CS;
            if (cs_falls - falls0 >= 5) En = 1'b0;
            if (SampleValid) begin vcyc[n] = cyc; vs[n] = Sample; n++; end
        end
        En = 1'b0;
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", n); end
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (vs[i] !== vals[i]) begin n_err++; $display("FAIL b2b_sample%0d: got %h want %h", i, vs[i], vals[i]); end
            $display("b2b conv %0d: sample=%h expected=%h cycle=%0d", i, vs[i], vals[i], vcyc[i]);
        end
        for (int i = 1; i < 5; i++) begin
            n_vec++; if (vcyc[i] - vcyc[i-1] !== FRAME) begin
                n_err++; $display("FAIL b2b_period%0d: got %0d want %0d", i, vcyc[i] - vcyc[i-1], FRAME);
            end
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_sclk_while_cs_high: got %0d edges want 0", bad); end
        wait_idle();
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b want 0", Busy); end
    endtask

    task automatic test_en_drop();
        logic [11:0] val = 12'h3C3;
        logic [11:0] got = 12'h000;
        int          falls0, rises = 0, n = 0;
        logic        prev;
        adc_q.delete();
        adc_q.push_back(val);
        falls0 = cs_falls;
        @(posedge Clk); #1;
        En   = 1'b1;
        prev = SCLK;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge Clk);
            if (SCLK && !prev) rises++;
            prev = SCLK;
            if (rises >= 11) En = 1'b0;
            if (SampleValid) begin n++; got = Sample; end
        end
        En = 1'b0;
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL endrop_valid_count: got %0d want 1", n); end
        n_vec++; if (got !== val) begin n_err++; $display("FAIL endrop_sample: got %h want %h", got, val); end
        n_vec++; if (cs_falls - falls0 !== 1) begin n_err++; $display("FAIL endrop_frames: got %0d want 1", cs_falls - falls0); end
        $display("en_drop: sample=%h expected=%h frames=%0d", got, val, cs_falls - falls0);
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] v2 = 12'($urandom);
        logic [11:0] got = 12'h000;
        int          falls = 0, n = 0, n2 = 0;
        bit          hit = 1'b0;
        logic        prev;
        adc_q.delete();
        adc_q.push_back(12'($urandom));
        adc_q.push_back(v2);
        @(posedge Clk); #1;
        En = 1'b1;
        @(posedge Clk); #1;
        En   = 1'b0;
        prev = SCLK;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge Clk);
            if (!SCLK && prev) falls++;
            prev = SCLK;
            if (falls == 8) hit = 1'b1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_bit8: got %0d falls want 8", falls); end
        n_vec++; if (CS !== 1'b1) begin n_err++; $display("FAIL rstmid_cs: got %b want 1", CS); end
        n_vec++; if (SCLK !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk: got %b want 0", SCLK); end
        n_vec++; if (Sample !== 12'h000) begin n_err++; $display("FAIL rstmid_sample: got %h want 000", Sample); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge Clk);
            if (SampleValid) n++;
        end
        n_vec++; if (n !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", n); end
        @(posedge Clk); #1;
        En = 1'b1;
        @(posedge Clk); #1;
        En = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge Clk);
            if (SampleValid) begin n2++; got = Sample; end
        end
        n_vec++; if (n2 !== 1) begin n_err++; $display("FAIL rstmid_restart_count: got %0d want 1", n2); end
        n_vec++; if (got !== v2) begin n_err++; $display("FAIL rstmid_restart_sample: got %h want %h", got, v2); end
        $display("reset_mid_frame: restart sample=%h expected=%h", got, v2);
    endtask

    task automatic test_averaging();
        logic [11:0] vals[4];
        logic [11:0] got, expv;
        int          sum, n, vf, falls0;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            sum = 0; n = 0; vf = -1; got = 12'h000;
            for (int i = 0; i < 4; i++) begin
                if (g == 0) vals[i] = 12'(12'h100 + i);
                else if (g == 1) vals[i] = 12'hFFF;
                else vals[i] = 12'($urandom);
                sum += int'(vals[i]);
            end
            expv = 12'(sum / 4);
            adc_q.delete();
            for (int i = 0; i < 4; i++) adc_q.push_back(vals[i]);
            falls0 = cs_falls;
            @(posedge Clk); #1;
            En = 1'b1;
            for (int i = 0; i < 6 * FRAME; i++) begin
                @(negedge Clk);
                if (cs_falls - falls0 >= 4) En = 1'b0;
                if (SampleValid) begin n++; got = Sample; vf = cs_falls - falls0; end
            end
            En = 1'b0;
            n_vec++; if (n !== 1) begin n_err++; $display("FAIL avg%0d_valid_count: got %0d want 1", g, n); end
            n_vec++; if (got !== expv) begin n_err++; $display("FAIL avg%0d_sample: got %h want %h", g, got, expv); end
            n_vec++; if (vf !== 4) begin n_err++; $display("FAIL avg%0d_after_frame: got %0d want 4", g, vf); end
            $display("avg group %0d: sample=%h expected=%h cycle=%0d", g, got, expv, cyc);
        end
    endtask

    initial begin
        Rst = 1'b1;
        En  = 1'b0;
        En0 = 1'b0;
        test_reset();
        test_command_bits();
`ifdef ADC_SPI_AVG_EN
        test_averaging();
`else
        test_single();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
